// File: rtl/handshake_fifo_152.sv
// handshake_fifo_152 -- valid/ready FIFO with registered storage.
//
// Purpose:
//   Buffers up to DEPTH words between an upstream producer and a downstream
//   consumer using a valid/ready handshake on both sides. Data leaves in strict
//   arrival order. ins_ready depends on registered occupancy only, so there is no
//   combinational path from outs_ready to ins_ready.
//
// Parameters:
//   DATA_WIDTH  width of the data channel
//   DEPTH       number of storage slots (power of two, >= 2)
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset (clears count and pointers only)
//   ins         upstream data
//   ins_valid   upstream data valid
//   ins_ready   FIFO can accept data (count != DEPTH)
//   outs        head-of-queue data (all-zeros when empty)
//   outs_valid  outs holds valid data
//   outs_ready  downstream accepts data
//
// Configuration:
//   HANDSHAKE_FIFO_152_BYPASS_EN  when defined, an empty FIFO forwards ins to outs
//                                 combinationally; a word taken by the consumer in
//                                 that same cycle never touches storage.
module handshake_fifo_152 #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] ins,
   input  logic                  ins_valid,
   output logic                  ins_ready,
   output logic [DATA_WIDTH-1:0] outs,
   output logic                  outs_valid,
   input  logic                  outs_ready
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

   logic [DATA_WIDTH-1:0] storage_q [DEPTH];
   logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]       count_q, count_d;

   logic empty;
   logic push;
   logic pop;
   logic bypass;

   assign empty     = (count_q == '0);
   assign ins_ready = (count_q != FullCnt);

`ifdef HANDSHAKE_FIFO_152_BYPASS_EN
   // Empty FIFO: present the upstream word directly. If the consumer takes it
   // now, the transfer completes here and nothing is stored.
   assign bypass     = empty & ins_valid & outs_ready;
   assign outs_valid = empty ? ins_valid : 1'b1;
   assign outs       = empty ? ins : storage_q[rd_ptr_q];
`else
   assign bypass     = 1'b0;
   assign outs_valid = ~empty;
   assign outs       = empty ? '0 : storage_q[rd_ptr_q];
`endif

   assign push = ins_valid & ins_ready & ~bypass;
   // Pops only ever come from storage; a bypassed word is not a pop.
   assign pop  = ~empty & outs_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is intentionally not reset; the reset-cycle handshake is dropped.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         storage_q[wr_ptr_q] <= ins;
      end
   end

`ifndef SYNTHESIS
   count_in_range: assert property (@(posedge clk) disable iff (rst) count_q <= FullCnt);

   held_output_stable: assert property (@(posedge clk) disable iff (rst)
      (outs_valid && !outs_ready) |=> (outs_valid && $stable(outs)));
`endif

endmodule

// File: tb/tb_handshake_fifo_152.sv
`timescale 1ns/1ps
module tb_handshake_fifo_152;

   localparam int unsigned DW    = 17;
   localparam int unsigned DEPTH = 4;

`ifdef HANDSHAKE_FIFO_152_BYPASS_EN
   localparam bit Byp = 1'b1;
`else
   localparam bit Byp = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] ins;
   logic          ins_valid;
   logic          ins_ready;
   logic [DW-1:0] outs;
   logic          outs_valid;
   logic          outs_ready;

   always #5 clk = ~clk;

   handshake_fifo_152 #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .ins        (ins),
      .ins_valid  (ins_valid),
      .ins_ready  (ins_ready),
      .outs       (outs),
      .outs_valid (outs_valid),
      .outs_ready (outs_ready)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: the FIFO contents as a plain queue, head at index 0.
   logic [DW-1:0] model_q[$];

   function automatic logic m_ready();
      return model_q.size() != DEPTH;
   endfunction

   function automatic logic m_valid();
      return (model_q.size() != 0) || (Byp && ins_valid);
   endfunction

   function automatic logic [DW-1:0] m_outs();
      if (model_q.size() != 0) return model_q[0];
      return Byp ? ins : '0;
   endfunction

   // Inputs change just after the falling edge; outputs are sampled 1ns later.
   task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic rs);
      ins_valid  = v;
      ins        = d;
      outs_ready = r;
      rst        = rs;
      #1;
   endtask

   // Advance one clock and apply the handshake rules to the model.
   task automatic tick();
      logic          push, pop, byp_xfer, r;
      logic [DW-1:0] d;
      push     = ins_valid && m_ready();
      pop      = m_valid() && outs_ready;
      byp_xfer = Byp && (model_q.size() == 0) && ins_valid && outs_ready;
      r        = rst;
      d        = ins;
      @(posedge clk);
      if (r) begin
         model_q.delete();
      end else if (!byp_xfer) begin
         if (pop) void'(model_q.pop_front());
         if (push) model_q.push_back(d);
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      drive(1'b0, '0, 1'b0, 1'b1);
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      drive(1'b0, '0, 1'b0, 1'b0);
      n_checks++;
      if (outs_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outs_valid: got %b expected 0", outs_valid);
      end
      n_checks++;
      if (outs !== '0) begin
         n_fail++;
         $display("FAIL reset_outs: got %h expected 0", outs);
      end
      n_checks++;
      if (ins_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ins_ready: got %b expected 1", ins_ready);
      end
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 17'h1EBE5, 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 17'h1EBE5, 1'b0, 1'b0);
      n_checks++;
      if (ins_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_ins_ready: got %b expected 0", ins_ready);
      end
      n_checks++;
      if (outs_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_outs_valid: got %b expected 1", outs_valid);
      end
      n_checks++;
      if (outs !== 17'h1EBE5) begin
         n_fail++;
         $display("FAIL fill_outs: got %h expected 1ebe5", outs);
      end
   endtask

   task automatic test_order();
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, DW'(i), 1'b0, 1'b0);
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, '0, 1'b1, 1'b0);
         n_checks++;
         if (outs_valid !== 1'b1 || outs !== DW'(k + 1)) begin
            n_fail++;
            $display("FAIL order_%0d: got valid=%b data=%h expected valid=1 data=%h",
                     k, outs_valid, outs, DW'(k + 1));
         end
         tick();
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (outs_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL order_drained: got valid=%b expected 0", outs_valid);
      end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, DW'(10 + i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, DW'(99), 1'b1, 1'b0);
      n_checks++;
      if (ins_ready !== 1'b0 || outs_valid !== 1'b1 || outs !== DW'(10)) begin
         n_fail++;
         $display("FAIL full_pop_cycle: got ready=%b valid=%b data=%h expected 0 1 %h",
                  ins_ready, outs_valid, outs, DW'(10));
      end
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      n_checks++;
      if (ins_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL full_next_ready: got %b expected 1", ins_ready);
      end
      n_checks++;
      if (dut.count_q !== 3'd3) begin
         n_fail++;
         $display("FAIL full_next_count: got %0d expected 3", dut.count_q);
      end
      n_checks++;
      if (outs !== DW'(11)) begin
         n_fail++;
         $display("FAIL full_next_head: got %h expected %h", outs, DW'(11));
      end
   endtask

   task automatic test_streaming();
      logic [DW-1:0] got[$];
      int            first;
      int            exp_first;
      first     = -1;
      exp_first = Byp ? 0 : 1;
      do_reset();
      for (int cyc = 0; cyc < 14; cyc++) begin
         drive(cyc < 10, DW'(cyc), 1'b1, 1'b0);
         if (outs_valid === 1'b1) begin
            if (first < 0) first = cyc;
            got.push_back(outs);
         end
         tick();
      end
      n_checks++;
      if (first != exp_first) begin
         n_fail++;
         $display("FAIL stream_latency: got first output at cycle %0d expected %0d",
                  first, exp_first);
      end
      n_checks++;
      if (got.size() != 10) begin
         n_fail++;
         $display("FAIL stream_count: got %0d words expected 10", got.size());
      end
      for (int i = 0; i < got.size() && i < 10; i++) begin
         n_checks++;
         if (got[i] !== DW'(i)) begin
            n_fail++;
            $display("FAIL stream_data_%0d: got %h expected %h", i, got[i], DW'(i));
         end
      end
   endtask

   task automatic test_wrap();
      logic [DW-1:0] sent[$];
      logic [DW-1:0] recv[$];
      logic          p;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         // 12 cycles of 3 pushes / 2 pops, then drain.
         p = (i < 12) && ((i % 5) < 3);
         drive(p, DW'(17'h100 + i), !p, 1'b0);
         n_checks++;
         if (outs_valid !== m_valid() || ins_ready !== m_ready() || outs !== m_outs()) begin
            n_fail++;
            $display("FAIL wrap_cycle_%0d: got valid=%b ready=%b data=%h expected %b %b %h",
                     i, outs_valid, ins_ready, outs, m_valid(), m_ready(), m_outs());
         end
         if (p && ins_ready) sent.push_back(ins);
         if (outs_valid && outs_ready) recv.push_back(outs);
         tick();
      end
      n_checks++;
      if (sent.size() != 8 || recv.size() != sent.size()) begin
         n_fail++;
         $display("FAIL wrap_count: got sent=%0d recv=%0d expected 8 8", sent.size(),
                  recv.size());
      end
      for (int i = 0; i < recv.size() && i < sent.size(); i++) begin
         n_checks++;
         if (recv[i] !== sent[i]) begin
            n_fail++;
            $display("FAIL wrap_order_%0d: got %h expected %h", i, recv[i], sent[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, DW'(17'h0AA0 + i), 1'b0, 1'b0);
         tick();
      end
      // Handshake offered on both sides during reset must be ignored.
      drive(1'b1, DW'(17'h55), 1'b1, 1'b1);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      n_checks++;
      if (outs_valid !== 1'b0 || outs !== '0 || ins_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_outputs: got valid=%b data=%h ready=%b expected 0 0 1",
                  outs_valid, outs, ins_ready);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, '0, 1'b1, 1'b0);
         n_checks++;
         if (outs_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_stale_%0d: got valid=%b data=%h expected valid=0",
                     i, outs_valid, outs);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic v, r, rs;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         v  = ($urandom_range(0, 3) != 0);
         r  = ($urandom_range(0, 2) != 0);
         rs = ($urandom_range(0, 63) == 0);
         drive(v, DW'($urandom), r, rs);
         n_checks++;
         if (outs_valid !== m_valid() || ins_ready !== m_ready() || outs !== m_outs()) begin
            n_fail++;
            $display("FAIL random_cycle_%0d: got valid=%b ready=%b data=%h expected %b %b %h",
                     i, outs_valid, ins_ready, outs, m_valid(), m_ready(), m_outs());
         end
         tick();
      end
   endtask

   initial begin
      rst        = 1'b1;
      ins        = '0;
      ins_valid  = 1'b0;
      outs_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_fill();
      test_order();
      test_full();
      test_streaming();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
